// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for the FP32 divider.
// The master side drives operands and accepts results; the slave side is the divider.
interface fp_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Out;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Out
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Out
    );
endinterface

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 binary32 divider: one restoring-division step per clock,
// truncating rounding, and denormal inputs treated as zero.
module fp_divider (
    input  logic        clk,
    input  logic        rst_n,
    fp_divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             r_state;
    state_t             w_next;
    logic [24:0]        r_rem;
    logic [23:0]        r_div;
    logic [24:0]        r_quo;
    logic [4:0]         r_cnt;
    logic signed [9:0]  r_exp;
    logic               r_sign;
    logic [31:0]        r_out;

    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic               w_sign;
    logic               w_accept;
    logic               w_special;
    logic [31:0]        w_special_val;
    logic               w_ge;
    logic [24:0]        w_diff;

    // Normalize the 25-bit quotient and saturate the exponent to inf/zero.
    function automatic logic [31:0] pack_result(input logic sign,
                                                input logic signed [9:0] exp_base,
                                                input logic [24:0] q);
        logic signed [9:0] e;
        logic [22:0]       m;
        if (q[24]) begin
            m = q[23:1];
            e = exp_base;
        end else begin
            m = q[22:0];
            e = exp_base - 10'sd1;
        end
        if (e >= 10'sd255)
            return {sign, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {sign, 31'd0};
        else
            return {sign, e[7:0], m};
    endfunction

    assign w_ea     = bus.A[30:23];
    assign w_eb     = bus.B[30:23];
    assign w_sign   = bus.A[31] ^ bus.B[31];
    assign w_accept = bus.in_valid && (r_state == IDLE);

    always_comb begin
        w_special     = 1'b1;
        w_special_val = QNAN;
        if (w_ea == 8'hFF || w_eb == 8'hFF)
            w_special_val = QNAN;
        else if (w_ea == 8'h00 && w_eb == 8'h00)
            w_special_val = QNAN;
        else if (w_ea == 8'h00)
            w_special_val = {w_sign, 31'd0};
        else if (w_eb == 8'h00)
            w_special_val = {w_sign, 8'hFF, 23'd0};
        else
            w_special = 1'b0;
    end

    // Restoring step: partial remainder always stays below twice the divisor.
    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_special ? DONE : CALC;
            CALC: if (r_cnt == 5'd24) w_next = NORM;
            NORM: w_next = DONE;
            DONE: if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_out  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_special) begin
                            r_out <= w_special_val;
                        end else begin
                            r_rem  <= {1'b0, 1'b1, bus.A[22:0]};
                            r_div  <= {1'b1, bus.B[22:0]};
                            r_quo  <= '0;
                            r_cnt  <= '0;
                            r_sign <= w_sign;
                            r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_diff << 1;
                    r_quo <= {r_quo[23:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                NORM: r_out <= pack_result(r_sign, r_exp, r_quo);
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.Out       = r_out;

endmodule

// File: tb/tb_fp_divider.sv
// Randomized self-checking bench for fp_divider against an integer-division
// reference of binary32 division with truncation.
module tb_fp_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    logic saw_valid;

    always #5 clk = ~clk;

    fp_divider_if bus();

    fp_divider u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    endtask

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        bit     s;
        longint ma, mb, q, mant;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 255 || eb == 255) return 32'h7FC0_0000;
        if (ea == 0 && eb == 0)     return 32'h7FC0_0000;
        if (ea == 0)                return {s, 31'd0};
        if (eb == 0)                return {s, 8'hFF, 23'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        q  = (ma * 64'd16777216) / mb;
        e  = ea - eb + 127;
        if (q >= 64'd16777216) begin
            mant = (q / 2) % 64'd8388608;
        end else begin
            mant = q % 64'd8388608;
            e    = e - 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), 23'(mant)};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_v, input int hold, input string tag);
        int          lat;
        int          exp_lat;
        logic [31:0] held;
        exp_lat = is_special(a, b) ? 0 : 26;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " Out"}, bus.Out, exp_v);
        held = bus.Out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold Out"}, bus.Out, held);
            check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " Out retained"}, bus.Out, held);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          mode;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset Out", bus.Out, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, "6/2");
        do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 0, "1/3");
        do_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 0, "-6/2");
        do_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0, "1/0");
        do_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0, "0/0");
        do_op(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0, "inf/1");
        do_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 0, "overflow");
        do_op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 0, "underflow");
        do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 5, "backpressure");
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, "after bp");

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = 32'h40C0_0000;
        bus.B = 32'h4000_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midcalc reset out_valid", 32'(bus.out_valid), 32'd0);
        check("midcalc reset in_ready", 32'(bus.in_ready), 32'd1);
        check("midcalc reset Out", bus.Out, 32'd0);
        #1 rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("aborted op no result", 32'(saw_valid), 32'd0);
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, "6/2 after reset");

        for (int k = 0; k < 30; k++) begin
            mode = int'($urandom_range(0, 9));
            ra = $urandom;
            rb = $urandom;
            ra[30:23] = 8'($urandom_range(1, 254));
            rb[30:23] = 8'($urandom_range(1, 254));
            if (mode == 0) ra[30:23] = 8'h00;
            if (mode == 1) rb[30:23] = 8'h00;
            if (mode == 2) ra[30:23] = 8'hFF;
            if (mode == 3) begin
                ra[30:23] = 8'($urandom_range(100, 150));
                rb[30:23] = 8'($urandom_range(100, 150));
            end
            do_op(ra, rb, ref_div(ra, rb), 0, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL have no parameters; the operand and result format is fixed IEEE-754 binary32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair A/B is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port A, input, 32 bits: dividend, FP32.
REQ-007 The block SHALL have port B, input, 32 bits: divisor, FP32.
REQ-008 The block SHALL have port out_valid, output, 1 bit: Out holds a completed quotient.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts Out.
REQ-010 The block SHALL have port Out, output, 32 bits: quotient A/B, FP32.

Function
REQ-011 The block SHALL use states IDLE, CALC, NORM and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Operands SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; A and B are latched at that edge and later changes are ignored.
REQ-014 Sign SHALL be A[31] XOR B[31] for every result, NaN excepted.
REQ-015 Special cases SHALL be checked at acceptance, highest priority first:
  - either exponent 255 -> Out=0x7FC00000;
  - both exponents 0 -> 0x7FC00000;
  - A exponent 0 -> signed zero;
  - B exponent 0 -> signed infinity (exp 255, mantissa 0).
  Denormals count as zero.
REQ-016 For a special case the state SHALL go IDLE->DONE, with out_valid high after exactly 1 edge.
REQ-017 For a normal case the state SHALL go IDLE->CALC, setting remainder = {1,A[22:0]} (25 bits), divisor = {1,B[22:0]}, and a quotient shift register to 0.
REQ-018 CALC SHALL perform exactly 25 restoring-division iterations, one per edge:
  - if remainder >= divisor: quotient bit 1 and remainder -= divisor; else quotient bit 0;
  - then the remainder shifts left 1;
  - quotient bits shift in MSB first.
REQ-019 After the 25th iteration the state SHALL go to NORM; the NORM edge registers the result and moves to DONE, so out_valid rises exactly 26 edges after the accepting edge.
REQ-020 Normalization SHALL use the 25-bit quotient q:
  - q[24]=1 -> mantissa q[23:1], exponent eA-eB+127;
  - else -> mantissa q[22:0], exponent eA-eB+126.
REQ-021 Exponent arithmetic SHALL use 10-bit signed width.
REQ-022 An exponent >= 255 SHALL give signed infinity; an exponent <= 0 SHALL give signed zero.
REQ-023 Rounding SHALL be truncation; the remainder is discarded.
REQ-024 In DONE, Out SHALL hold stable while out_ready=0; on an edge with out_ready=1 the state SHALL go to IDLE and out_valid falls.
REQ-025 A new operand SHALL be accepted at the earliest one edge after the DONE->IDLE edge; there is no overlap of operations.
REQ-026 Out SHALL retain its last value outside DONE.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, in_ready=1, out_valid=0, Out=0, and clear the remainder, divisor and quotient.
REQ-028 Reset asserted in CALC, NORM or DONE SHALL abort the operation; no result is produced for it after release.
REQ-029 After rst_n rises, the first rising edge SHALL be able to accept operands.

Verification
REQ-030 0x40C00000 / 0x40000000 (6/2) -> Out=0x40400000, out_valid 26 edges after accept.
REQ-031 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated); 0xC0C00000 / 0x40000000 -> 0xC0400000.
REQ-032 0x3F800000 / 0x00000000 -> 0x7F800000 after 1 edge; 0x00000000 / 0x00000000 -> 0x7FC00000; 0x7F800000 / 0x3F800000 -> 0x7FC00000.
REQ-033 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow); 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
REQ-034 Backpressure test:
  - hold out_ready=0 for 5 cycles in DONE -> Out and out_valid stable, in_ready=0;
  - raise out_ready -> IDLE next edge;
  - a new operand pair is accepted at the following edge.
REQ-035 Reset test:
  - pulse rst_n low between two edges mid-CALC -> out_valid=0, in_ready=1 with no clock edge;
  - the next operation, 6/2, yields 0x40400000.
